// File: rtl/pipe_hazard_ctrl.sv
// Pipeline scoreboard/control: RAW detection, forwarding selects, stall, branch flush, memory freeze.
// Combinational outputs from registered stage tags; i_mem_stall freezes all state.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 4,
  parameter int NREGS      = 8,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int BR_STAGE   = 1,
  parameter int FWD_EN     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_fetch_valid,
  input  logic [$clog2(NREGS)-1:0]     i_dec_rs1,
  input  logic                         i_dec_rs1_used,
  input  logic [$clog2(NREGS)-1:0]     i_dec_rs2,
  input  logic                         i_dec_rs2_used,
  input  logic [$clog2(NREGS)-1:0]     i_dec_ws,
  input  logic                         i_dec_we,
  input  logic                         i_dec_late,
  input  logic                         i_br_taken,
  input  logic                         i_mem_stall,
  output logic                         o_dec_valid,
  output logic                         o_stall,
  output logic                         o_flush,
  output logic                         o_pc_enable,
  output logic [STAGES-1:0]            o_stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  o_fwd_sel1,
  output logic [$clog2(STAGES+1)-1:0]  o_fwd_sel2,
  output logic                         o_wb_we,
  output logic [$clog2(NREGS)-1:0]     o_wb_ws
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(STAGES+1);

  logic              dec_valid;
  logic [STAGES:1]   valid;
  logic [STAGES:1]   we;
  logic [STAGES:1]   late;
  logic [RW-1:0]     ws [1:STAGES];

  logic [SW-1:0]     m1, m2;
  logic              f1, f2, r1, r2;
  logic              hazard, br;

  // Scan oldest to youngest so the lowest matching stage is left in m*/r*.
  always_comb begin
    m1 = '0;
    m2 = '0;
    f1 = 1'b0;
    f2 = 1'b0;
    r1 = 1'b0;
    r2 = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (i_dec_rs1_used && valid[k] && we[k] && (ws[k] == i_dec_rs1)) begin
        m1 = SW'(k);
        f1 = 1'b1;
        r1 = (k >= (late[k] ? LOAD_READY : ALU_READY));
      end
      if (i_dec_rs2_used && valid[k] && we[k] && (ws[k] == i_dec_rs2)) begin
        m2 = SW'(k);
        f2 = 1'b1;
        r2 = (k >= (late[k] ? LOAD_READY : ALU_READY));
      end
    end
  end

  assign hazard = dec_valid & ((f1 & ~r1) | (f2 & ~r2) | ((FWD_EN == 0) & (f1 | f2)));
  assign br     = ~reset & i_br_taken & valid[BR_STAGE] & ~i_mem_stall;

  assign o_dec_valid   = dec_valid;
  assign o_stage_valid = valid;
  assign o_flush       = br;
  assign o_stall       = ~reset & hazard & ~br & ~i_mem_stall;
  assign o_pc_enable   = ~reset & ~i_mem_stall & (br | ~hazard);
  assign o_fwd_sel1    = (!reset && FWD_EN != 0 && dec_valid && f1 && r1) ? m1 : '0;
  assign o_fwd_sel2    = (!reset && FWD_EN != 0 && dec_valid && f2 && r2) ? m2 : '0;
  assign o_wb_we       = ~reset & valid[STAGES] & we[STAGES] & ~i_mem_stall;
  assign o_wb_ws       = ws[STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid <= 1'b0;
      valid     <= '0;
    end else if (!i_mem_stall) begin
      for (int k = STAGES; k >= 2; k--)
        valid[k] <= valid[k-1] & ~(br & (k <= BR_STAGE));
      valid[1] <= dec_valid & ~hazard & ~br;
      if (br)
        dec_valid <= 1'b0;
      else if (!hazard)
        dec_valid <= i_fetch_valid;
    end
  end

  // Tags need no reset: every consumer is qualified by the matching valid bit.
  always_ff @(posedge clk) begin
    if (!i_mem_stall) begin
      for (int k = STAGES; k >= 2; k--) begin
        ws[k]   <= ws[k-1];
        we[k]   <= we[k-1];
        late[k] <= late[k-1];
      end
      ws[1]   <= i_dec_ws;
      we[1]   <= i_dec_we;
      late[1] <= i_dec_late;
    end
  end
endmodule
